// File: rtl/digiclock_ctrl.sv
// rtl/digiclock_ctrl.sv - digital clock time-keeping controller
// 1 s clock-enable prescaler, hh:mm:ss BCD counters and RUN/SET_HOUR/SET_MIN mode FSM.
module digiclock_ctrl #(
    parameter int TICK_DIV  = 100_000_000,
    parameter int BLINK_DIV = 25_000_000
) (
    input  logic       clk_100M,
    input  logic       sys_rst_n,
    input  logic       btn_mode,
    input  logic       btn_inc,
    output logic [7:0] hour_bcd,
    output logic [7:0] min_bcd,
    output logic [7:0] sec_bcd,
    output logic [1:0] mode,
    output logic       blink,
    output logic       sec_tick
);

    localparam int TW = $clog2(TICK_DIV);
    localparam int BW = $clog2(BLINK_DIV);
    localparam logic [TW-1:0] TICK_LAST  = TW'(TICK_DIV - 1);
    localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_DIV - 1);

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        SET_HOUR = 2'd1,
        SET_MIN  = 2'd2
    } state_t;

    state_t          state;
    state_t          state_nxt;
    logic [TW-1:0]   presc_cnt;
    logic [BW-1:0]   blink_cnt;
    logic            tick;
    logic            inc_ok;
    logic            enter_run;
    logic            sec_wrap;
    logic            min_wrap;

    // Wraps at last, otherwise BCD increment with decimal carry between digits.
    function automatic logic [7:0] bcd_inc(input logic [7:0] v, input logic [7:0] last);
        if (v == last)
            return 8'h00;
        else if (v[3:0] == 4'd9)
            return {v[7:4] + 4'd1, 4'd0};
        else
            return {v[7:4], v[3:0] + 4'd1};
    endfunction

    always_ff @(posedge clk_100M or negedge sys_rst_n) begin
        if (!sys_rst_n)
            state <= RUN;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        if (btn_mode) begin
            case (state)
                RUN:      state_nxt = SET_HOUR;
                SET_HOUR: state_nxt = SET_MIN;
                default:  state_nxt = RUN;
            endcase
        end
    end

    // A mode press always wins over both the timebase and an increment.
    assign tick      = (state == RUN) && !btn_mode && (presc_cnt == TICK_LAST);
    assign inc_ok    = btn_inc && !btn_mode && (state != RUN);
    assign enter_run = btn_mode && (state == SET_MIN);
    assign sec_wrap  = (sec_bcd == 8'h59);
    assign min_wrap  = (min_bcd == 8'h59);

    always_ff @(posedge clk_100M or negedge sys_rst_n) begin
        if (!sys_rst_n)
            presc_cnt <= '0;
        else if (state != RUN || btn_mode || tick)
            presc_cnt <= '0;
        else
            presc_cnt <= presc_cnt + 1'b1;
    end

    always_ff @(posedge clk_100M or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            sec_bcd  <= 8'h00;
            min_bcd  <= 8'h00;
            hour_bcd <= 8'h00;
            sec_tick <= 1'b0;
        end else begin
            sec_tick <= tick;
            if (enter_run)
                sec_bcd <= 8'h00;
            else if (tick)
                sec_bcd <= bcd_inc(sec_bcd, 8'h59);

            if (tick && sec_wrap)
                min_bcd <= bcd_inc(min_bcd, 8'h59);
            else if (inc_ok && state == SET_MIN)
                min_bcd <= bcd_inc(min_bcd, 8'h59);

            if (tick && sec_wrap && min_wrap)
                hour_bcd <= bcd_inc(hour_bcd, 8'h23);
            else if (inc_ok && state == SET_HOUR)
                hour_bcd <= bcd_inc(hour_bcd, 8'h23);
        end
    end

    // Mode entry and accepted increments restart the blink phase in the visible half.
    always_ff @(posedge clk_100M or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            blink_cnt <= '0;
            blink     <= 1'b1;
        end else if (state_nxt == RUN || btn_mode || inc_ok) begin
            blink_cnt <= '0;
            blink     <= 1'b1;
        end else if (blink_cnt == BLINK_LAST) begin
            blink_cnt <= '0;
            blink     <= ~blink;
        end else begin
            blink_cnt <= blink_cnt + 1'b1;
        end
    end

    assign mode = state;

endmodule

// File: tb/tb_digiclock_ctrl.sv
// tb/tb_digiclock_ctrl.sv - self-checking bench for digiclock_ctrl
module tb_digiclock_ctrl;
    localparam int TD = 10;
    localparam int BD = 3;

    logic       clk_100M = 1'b0;
    logic       sys_rst_n = 1'b0;
    logic       btn_mode = 1'b0;
    logic       btn_inc = 1'b0;
    logic [7:0] hour_bcd, min_bcd, sec_bcd;
    logic [1:0] mode;
    logic       blink, sec_tick;

    int total = 0;
    int bad = 0;

    // Reference model: time as seconds of day, counters of edges since phase restarts.
    int m_secs, m_mode, m_run_cyc, m_blink_cyc;
    bit m_tick;

    digiclock_ctrl #(.TICK_DIV(TD), .BLINK_DIV(BD)) dut (
        .clk_100M (clk_100M),
        .sys_rst_n(sys_rst_n),
        .btn_mode (btn_mode),
        .btn_inc  (btn_inc),
        .hour_bcd (hour_bcd),
        .min_bcd  (min_bcd),
        .sec_bcd  (sec_bcd),
        .mode     (mode),
        .blink    (blink),
        .sec_tick (sec_tick)
    );

    always #5 clk_100M = ~clk_100M;

    function automatic logic [7:0] to_bcd(input int v);
        return 8'(((v / 10) << 4) | (v % 10));
    endfunction

    function automatic logic [7:0] e_hour();
        return to_bcd(m_secs / 3600);
    endfunction
    function automatic logic [7:0] e_min();
        return to_bcd((m_secs / 60) % 60);
    endfunction
    function automatic logic [7:0] e_sec();
        return to_bcd(m_secs % 60);
    endfunction
    function automatic logic e_blink();
        return (m_mode == 0) ? 1'b1 : (((m_blink_cyc / BD) % 2) == 0);
    endfunction

    task automatic model_reset();
        m_secs = 0; m_mode = 0; m_run_cyc = 0; m_blink_cyc = 0; m_tick = 0;
    endtask

    task automatic model_step(input bit bm, input bit bi);
        int h, m, s;
        h = m_secs / 3600; m = (m_secs / 60) % 60; s = m_secs % 60;
        m_tick = 0;
        if (bm) begin
            m_blink_cyc = 0;
            if (m_mode == 0) m_mode = 1;
            else if (m_mode == 1) m_mode = 2;
            else begin
                m_mode = 0; m_run_cyc = 0; s = 0;
            end
        end else if (m_mode == 0) begin
            m_run_cyc++;
            if (m_run_cyc % TD == 0) begin
                m_secs = (m_secs + 1) % 86400;
                m_tick = 1;
                return;
            end
        end else if (bi) begin
            m_blink_cyc = 0;
            if (m_mode == 1) h = (h + 1) % 24;
            else m = (m + 1) % 60;
        end else begin
            m_blink_cyc++;
        end
        m_secs = h * 3600 + m * 60 + s;
    endtask

    task automatic cycle(input bit bm, input bit bi);
        btn_mode = bm;
        btn_inc  = bi;
        @(posedge clk_100M);
        model_step(bm, bi);
        #1;
        btn_mode = 1'b0;
        btn_inc  = 1'b0;
    endtask

    task automatic test_reset();
        sys_rst_n = 1'b0;
        #23;
        total++;
        if ({hour_bcd, min_bcd, sec_bcd, mode, blink, sec_tick} !== {24'h000000, 2'd0, 1'b1, 1'b0}) begin
            bad++;
            $display("FAIL reset_state actual=%h_%h_%h m%0d b%0d t%0d required=00_00_00 m0 b1 t0",
                     hour_bcd, min_bcd, sec_bcd, mode, blink, sec_tick);
        end
        @(negedge clk_100M);
        sys_rst_n = 1'b1;
        model_reset();
    endtask

    task automatic test_first_ticks();
        int edges[$];
        for (int i = 1; i <= 35; i++) begin
            cycle(0, 0);
            if (sec_tick === 1'b1) edges.push_back(i);
        end
        total++;
        if (edges.size() != 3 || edges[0] != 10 || edges[1] != 20 || edges[2] != 30) begin
            bad++;
            $display("FAIL first_tick_edges actual_count=%0d required=3 at 10,20,30", edges.size());
        end
        total++;
        if (sec_bcd !== 8'h03 || mode !== 2'd0 || blink !== 1'b1) begin
            bad++;
            $display("FAIL first_ticks_state actual=sec%h m%0d b%0d required=sec03 m0 b1", sec_bcd, mode, blink);
        end
    endtask

    task automatic test_set_wrap();
        cycle(1, 0);
        repeat (23) cycle(0, 1);
        cycle(1, 0);
        repeat (59) cycle(0, 1);
        cycle(1, 0);
        total++;
        if ({hour_bcd, min_bcd, sec_bcd} !== 24'h235900 || mode !== 2'd0) begin
            bad++;
            $display("FAIL set_2359 actual=%h%h%h m%0d required=235900 m0", hour_bcd, min_bcd, sec_bcd, mode);
        end
        repeat (599) cycle(0, 0);
        total++;
        if ({hour_bcd, min_bcd, sec_bcd, sec_tick} !== {24'h235959, 1'b0}) begin
            bad++;
            $display("FAIL pre_wrap actual=%h%h%h t%0d required=235959 t0", hour_bcd, min_bcd, sec_bcd, sec_tick);
        end
        cycle(0, 0);
        total++;
        if ({hour_bcd, min_bcd, sec_bcd, sec_tick} !== {24'h000000, 1'b1}) begin
            bad++;
            $display("FAIL day_wrap actual=%h%h%h t%0d required=000000 t1", hour_bcd, min_bcd, sec_bcd, sec_tick);
        end
    endtask

    task automatic test_inc_wrap();
        int ticks = 0;
        cycle(1, 0);
        for (int i = 0; i < 25; i++) begin
            cycle(0, 1);
            ticks += int'(sec_tick);
        end
        total++;
        if (hour_bcd !== 8'h01) begin
            bad++;
            $display("FAIL hour_inc_wrap actual=%h required=01", hour_bcd);
        end
        cycle(1, 0);
        for (int i = 0; i < 61; i++) begin
            cycle(0, 1);
            ticks += int'(sec_tick);
        end
        total++;
        if (min_bcd !== 8'h01 || hour_bcd !== 8'h01 || mode !== 2'd2) begin
            bad++;
            $display("FAIL min_inc_wrap actual=%h:%h m%0d required=01:01 m2", hour_bcd, min_bcd, mode);
        end
        total++;
        if (ticks != 0) begin
            bad++;
            $display("FAIL no_tick_in_set actual=%0d required=0", ticks);
        end
    endtask

    task automatic test_simultaneous();
        logic exp_b;
        cycle(1, 0);
        cycle(1, 0);
        cycle(1, 1);
        total++;
        if (mode !== 2'd2 || hour_bcd !== 8'h01 || blink !== 1'b1) begin
            bad++;
            $display("FAIL mode_wins actual=m%0d h%h b%0d required=m2 h01 b1", mode, hour_bcd, blink);
        end
        for (int k = 1; k <= 6; k++) begin
            cycle(0, 0);
            exp_b = (k >= 3 && k <= 5) ? 1'b0 : 1'b1;
            total++;
            if (blink !== exp_b || blink !== e_blink()) begin
                bad++;
                $display("FAIL blink_phase k=%0d actual=%0d required=%0d", k, blink, exp_b);
            end
        end
    endtask

    task automatic test_exit_run();
        cycle(1, 0);
        repeat (420) cycle(0, 0);
        cycle(1, 0);
        repeat (5) cycle(0, 0);
        cycle(1, 0);
        repeat (4) cycle(0, 0);
        total++;
        if (sec_bcd !== 8'h42 || sec_tick !== 1'b0 || mode !== 2'd2) begin
            bad++;
            $display("FAIL sec_frozen actual=%h t%0d m%0d required=42 t0 m2", sec_bcd, sec_tick, mode);
        end
        cycle(1, 0);
        total++;
        if (sec_bcd !== 8'h00 || mode !== 2'd0) begin
            bad++;
            $display("FAIL sec_clear actual=%h m%0d required=00 m0", sec_bcd, mode);
        end
        for (int k = 1; k <= 10; k++) begin
            cycle(0, 0);
            total++;
            if (sec_tick !== (k == 10)) begin
                bad++;
                $display("FAIL run_first_tick k=%0d actual=%0d required=%0d", k, sec_tick, (k == 10));
            end
        end
        total++;
        if (sec_bcd !== 8'h01) begin
            bad++;
            $display("FAIL run_first_sec actual=%h required=01", sec_bcd);
        end
    endtask

    task automatic test_random();
        bit bm, bi;
        for (int i = 0; i < 400; i++) begin
            bm = ($urandom_range(39) == 0);
            bi = ($urandom_range(3) == 0);
            cycle(bm, bi);
            total++;
            if ({hour_bcd, min_bcd, sec_bcd, mode, blink, sec_tick} !==
                {e_hour(), e_min(), e_sec(), 2'(m_mode), e_blink(), m_tick}) begin
                bad++;
                $display("FAIL random_cycle%0d actual=%h%h%h m%0d b%0d t%0d required=%h%h%h m%0d b%0d t%0d",
                         i, hour_bcd, min_bcd, sec_bcd, mode, blink, sec_tick,
                         e_hour(), e_min(), e_sec(), m_mode, e_blink(), m_tick);
            end
        end
    endtask

    task automatic test_reset_mid();
        for (int i = 0; i < 3 && m_mode != 1; i++) cycle(1, 0);
        for (int i = 0; i < 24 && m_secs / 3600 != 12; i++) cycle(0, 1);
        cycle(1, 0);
        for (int i = 0; i < 60 && (m_secs / 60) % 60 != 34; i++) cycle(0, 1);
        cycle(1, 0);
        repeat (560) cycle(0, 0);
        total++;
        if ({hour_bcd, min_bcd, sec_bcd} !== 24'h123456) begin
            bad++;
            $display("FAIL reach_123456 actual=%h%h%h required=123456", hour_bcd, min_bcd, sec_bcd);
        end
        cycle(1, 0);
        cycle(1, 0);
        repeat (2) cycle(0, 0);
        #2;
        sys_rst_n = 1'b0;
        #1;
        total++;
        if ({hour_bcd, min_bcd, sec_bcd, mode, blink, sec_tick} !== {24'h000000, 2'd0, 1'b1, 1'b0}) begin
            bad++;
            $display("FAIL async_reset actual=%h%h%h m%0d b%0d t%0d required=000000 m0 b1 t0",
                     hour_bcd, min_bcd, sec_bcd, mode, blink, sec_tick);
        end
        @(negedge clk_100M);
        sys_rst_n = 1'b1;
        model_reset();
        repeat (TD) cycle(0, 0);
        total++;
        if (sec_bcd !== 8'h01 || sec_tick !== 1'b1) begin
            bad++;
            $display("FAIL post_reset_tick actual=%h t%0d required=01 t1", sec_bcd, sec_tick);
        end
    endtask

    initial begin
        test_reset();
        test_first_ticks();
        test_set_wrap();
        test_inc_wrap();
        test_simultaneous();
        test_exit_run();
        test_random();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
